// File: rtl/aes_cipher_ctrl.sv
// AES encryption engine. Runs one cipher round per clock on a single 128-bit
// state register. The key schedule is expanded outside this block and
// presented as one wide vector with round key 0 in the most significant bits.
// One block is in flight at a time, and a result is held until it is taken.
module aes_cipher_ctrl #(
    parameter int NR = 10,
    parameter int NK = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [127:0]          in_block,
    input  logic                  key_ready,
    input  logic [128*(NR+1)-1:0] round_keys,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [127:0]          out_block,
    output logic                  busy,
    output logic [3:0]            round
);

    // An unsupported NK/NR pairing never accepts a block, so it cannot emit
    // ciphertext for a key size it does not implement.
    localparam bit CFG_OK = (NK == 4 && NR == 10) ||
                            (NK == 6 && NR == 12) ||
                            (NK == 8 && NR == 14);

    // Round number at which the full-round phase ends and the final round begins.
    localparam logic [3:0] LAST_ROUND = 4'(NR);

    // The forward S-box. Entry 0 is in the most significant byte.
    localparam logic [2047:0] SBOX_FLAT = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        FINAL = 2'd2,
        DONE  = 2'd3
    } fsm_t;

    fsm_t         fsm_reg;
    logic [127:0] state_reg;
    logic [3:0]   round_reg;
    logic         out_valid_reg;
    logic         busy_reg;

    logic [127:0] rk [NR+1];
    logic [127:0] sb_next;
    logic [127:0] sr_next;
    logic [127:0] mc_next;
    logic [127:0] round_next;
    logic [127:0] final_next;
    logic [3:0]   round_inc;

    // S-box lookup. The byte value selects an 8-bit slice, counted from the top.
    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX_FLAT[2047 - {b, 3'b000} -: 8];
    endfunction

    // Multiply by x in GF(2^8) using the AES polynomial.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // MixColumns on one column. Byte 0 of the column is in the MSBs.
    function automatic logic [31:0] mix_col(input logic [31:0] col);
        logic [7:0] a0;
        logic [7:0] a1;
        logic [7:0] a2;
        logic [7:0] a3;
        {a0, a1, a2, a3} = col;
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    genvar gi;

    // Split the flat schedule into per-round keys. Key 0 sits at the MSBs.
    generate
        for (gi = 0; gi <= NR; gi++) begin : g_rk
            assign rk[gi] = round_keys[128*(NR+1)-1-128*gi -: 128];
        end
    endgenerate

    // SubBytes and ShiftRows, one byte lane at a time. The state is
    // column-major: byte index = row + 4*col, and byte 0 is in the MSBs.
    // Row r rotates left by r columns.
    generate
        for (gi = 0; gi < 16; gi++) begin : g_byte
            localparam int ROW  = gi % 4;
            localparam int COL  = gi / 4;
            localparam int SRC  = ROW + 4 * ((COL + ROW) % 4);
            assign sb_next[127-8*gi -: 8] = sbox(state_reg[127-8*gi -: 8]);
            assign sr_next[127-8*gi -: 8] = sb_next[127-8*SRC -: 8];
        end
    endgenerate

    // MixColumns on each of the four columns.
    generate
        for (gi = 0; gi < 4; gi++) begin : g_col
            assign mc_next[127-32*gi -: 32] = mix_col(sr_next[127-32*gi -: 32]);
        end
    endgenerate

    // Results of a full round and of the final round (the final round has no MixColumns).
    // The round key is indexed by the counter, which never exceeds NR.
    assign round_inc  = round_reg + 4'd1;
    assign round_next = mc_next ^ rk[round_reg];
    assign final_next = sr_next ^ rk[NR];

    // Accept only from IDLE, with a valid schedule, and never during reset.
    assign in_ready  = CFG_OK && (fsm_reg == IDLE) && key_ready && !rst;
    assign out_valid = out_valid_reg;
    assign out_block = out_valid_reg ? state_reg : 128'd0;
    assign busy      = busy_reg;
    assign round     = round_reg;

    // Sequencer: accept a block, run NR-1 full rounds and then one final
    // round, then hold the result until the consumer takes it.
    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_reg       <= IDLE;
            state_reg     <= '0;
            round_reg     <= '0;
            out_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
        end else begin
            case (fsm_reg)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        state_reg <= in_block ^ rk[0];
                        round_reg <= 4'd1;
                        busy_reg  <= 1'b1;
                        fsm_reg   <= ROUND;
                    end
                end
                ROUND: begin
                    state_reg <= round_next;
                    round_reg <= round_inc;
                    if (round_inc == LAST_ROUND) begin
                        fsm_reg <= FINAL;
                    end
                end
                FINAL: begin
                    state_reg     <= final_next;
                    out_valid_reg <= 1'b1;
                    fsm_reg       <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        round_reg     <= '0;
                        out_valid_reg <= 1'b0;
                        busy_reg      <= 1'b0;
                        fsm_reg       <= IDLE;
                    end
                end
                default: begin
                    fsm_reg       <= IDLE;
                    state_reg     <= '0;
                    round_reg     <= '0;
                    out_valid_reg <= 1'b0;
                    busy_reg      <= 1'b0;
                end
            endcase
        end
    end

endmodule
